// File: rtl/alu_4b_pkg.sv
// Shared opcodes, sizing constants and FSM states for the 4-bit ALU issue slice.
package alu_4b_pkg;

   localparam int unsigned NREG = 8;
   localparam int unsigned W    = 4;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   function automatic logic is_legal_op(input logic [2:0] op);
      return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
   endfunction

endpackage

// File: rtl/alu_issue_4b_if.sv
// Instruction handshake, ALU hookup, writeback and debug signals of alu_issue_4b.
interface alu_issue_4b_if;
   import alu_4b_pkg::*;

   logic           in_valid;
   logic           in_ready;
   logic [2:0]     in_op;
   logic [2:0]     in_rd;
   logic [2:0]     in_rs;
   logic [2:0]     in_rt;
   logic           in_use_imm;
   logic [W-1:0]   in_imm;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic [2:0]     alu_op;
   logic [W-1:0]   alu_r;
   logic           wb_valid;
   logic [2:0]     wb_rd;
   logic [W-1:0]   wb_data;
   logic           illegal;
   logic [2:0]     dbg_addr;
   logic [W-1:0]   dbg_data;

   modport master (
      output in_valid, in_op, in_rd, in_rs, in_rt, in_use_imm, in_imm, alu_r, dbg_addr,
      input  in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, illegal, dbg_data
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs, in_rt, in_use_imm, in_imm, alu_r, dbg_addr,
      output in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, illegal, dbg_data
   );

endinterface

// File: rtl/alu_4b.sv
// Combinational 4-bit ALU: AND, OR, ADD, SUB (mod 16) and signed set-less-than.
module alu_4b (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [2:0] op,
   output logic [3:0] r
);
   import alu_4b_pkg::*;

   always_comb begin
      r = '0;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_SLT:  r = {3'b000, ($signed(a) < $signed(b))};
         default: r = '0;
      endcase
   end

endmodule

// File: rtl/regfile_8x4.sv
// Register file: two async read ports, debug read port, one sync write port, r0 fixed at zero.
module regfile_8x4 #(
   parameter int unsigned NREG = 8,
   parameter int unsigned W    = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   ra1,
   output logic [W-1:0] rd1,
   input  logic [2:0]   ra2,
   output logic [W-1:0] rd2,
   input  logic [2:0]   dbg_addr,
   output logic [W-1:0] dbg_data,
   input  logic         we,
   input  logic [2:0]   wa,
   input  logic [W-1:0] wd
);
   logic [W-1:0] mem [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem <= '{default: '0};
      end else if (we && (wa != '0)) begin
         mem[wa] <= wd;
      end
   end

   assign rd1      = (ra1 == '0)      ? '0 : mem[ra1];
   assign rd2      = (ra2 == '0)      ? '0 : mem[ra2];
   assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_4b.sv
// Serialised issue/writeback stage: IDLE -> READ -> EXEC -> WB around an external alu_4b.
module alu_issue_4b #(
   parameter int unsigned NREG = 8,
   parameter int unsigned W    = 4
) (
   input logic           clk,
   input logic           rst,
   alu_issue_4b_if.slave bus
);
   import alu_4b_pkg::*;

   state_t       state;
   logic [2:0]   op_q;
   logic [2:0]   rd_q;
   logic [2:0]   rs_q;
   logic [2:0]   rt_q;
   logic         use_imm_q;
   logic [W-1:0] imm_q;
   logic [W-1:0] rs_data;
   logic [W-1:0] rt_data;
   logic         wr_en;

   // wb_data doubles as the result register; the write lands on the edge leaving WB
   assign wr_en        = (state == WB) && bus.wb_valid;
   assign bus.in_ready = (state == IDLE);

   regfile_8x4 #(.NREG(NREG), .W(W)) u_rf (
      .clk      (clk),
      .rst      (rst),
      .ra1      (rs_q),
      .rd1      (rs_data),
      .ra2      (rt_q),
      .rd2      (rt_data),
      .dbg_addr (bus.dbg_addr),
      .dbg_data (bus.dbg_data),
      .we       (wr_en),
      .wa       (rd_q),
      .wd       (bus.wb_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         op_q         <= '0;
         rd_q         <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         use_imm_q    <= 1'b0;
         imm_q        <= '0;
         bus.alu_a    <= '0;
         bus.alu_b    <= '0;
         bus.alu_op   <= '0;
         bus.wb_valid <= 1'b0;
         bus.illegal  <= 1'b0;
         bus.wb_rd    <= '0;
         bus.wb_data  <= '0;
      end else begin
         bus.wb_valid <= 1'b0;
         bus.illegal  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  op_q      <= bus.in_op;
                  rd_q      <= bus.in_rd;
                  rs_q      <= bus.in_rs;
                  rt_q      <= bus.in_rt;
                  use_imm_q <= bus.in_use_imm;
                  imm_q     <= bus.in_imm;
                  state     <= READ;
               end
            end
            READ: begin
               bus.alu_a  <= rs_data;
               bus.alu_b  <= use_imm_q ? imm_q : rt_data;
               bus.alu_op <= op_q;
               state      <= EXEC;
            end
            EXEC: begin
               bus.wb_rd    <= rd_q;
               bus.wb_data  <= bus.alu_r;
               bus.wb_valid <= is_legal_op(op_q);
               bus.illegal  <= !is_legal_op(op_q);
               state        <= WB;
            end
            WB: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_4b.sv
// Self-checking bench for alu_issue_4b wired to alu_4b, against a behavioural register/ALU model.
module tb_alu_issue_4b;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   logic [3:0] mregs [8];

   alu_issue_4b_if bus ();

   alu_issue_4b #(.NREG(8), .W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   alu_4b u_alu (
      .a  (bus.alu_a),
      .b  (bus.alu_b),
      .op (bus.alu_op),
      .r  (bus.alu_r)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit ref_legal(input logic [2:0] op);
      return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd6) || (op == 3'd7);
   endfunction

   function automatic int to_signed4(input logic [3:0] x);
      return (int'(x) > 7) ? int'(x) - 16 : int'(x);
   endfunction

   function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return 4'((int'(a) + int'(b)) % 16);
         3'd6:    return 4'((int'(a) - int'(b) + 16) % 16);
         3'd7:    return (to_signed4(a) < to_signed4(b)) ? 4'd1 : 4'd0;
         default: return 4'd0;
      endcase
   endfunction

   task automatic put(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [2:0] rt, input logic use_imm, input logic [3:0] imm);
      bus.in_op      = op;
      bus.in_rd      = rd;
      bus.in_rs      = rs;
      bus.in_rt      = rt;
      bus.in_use_imm = use_imm;
      bus.in_imm     = imm;
   endtask

   // One full instruction: handshake, operand/writeback/timing checks, then model update.
   task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input logic use_imm, input logic [3:0] imm);
      logic [3:0] a, b, exp;
      bit         legal;
      int         pulses, at;
      a      = mregs[rs];
      b      = use_imm ? imm : mregs[rt];
      exp    = ref_alu(op, a, b);
      legal  = ref_legal(op);
      pulses = 0;
      at     = 0;
      put(op, rd, rs, rt, use_imm, imm);
      bus.in_valid = 1'b1;
      for (int t = 0; t < 16 && !bus.in_ready; t++) @(negedge clk);
      if (!bus.in_ready) begin
         n_checks++;
         $display("FAIL handshake_timeout: in_ready=%0b required 1", bus.in_ready);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         if (bus.wb_valid || bus.illegal) begin
            pulses++;
            at = n;
         end
         if (n == 2) begin
            n_checks++;
            if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {a, b, op})
               $display("FAIL alu_operands: a/b/op=%h/%h/%h required %h/%h/%h", bus.alu_a, bus.alu_b, bus.alu_op, a, b, op);
            else n_pass++;
         end
         if (n == 3) begin
            n_checks++;
            if ({bus.wb_valid, bus.illegal} !== {legal, !legal})
               $display("FAIL wb_flags op=%b: wb_valid/illegal=%b%b required %b%b", op, bus.wb_valid, bus.illegal, legal, !legal);
            else n_pass++;
            if (legal) begin
               n_checks++;
               if ({bus.wb_rd, bus.wb_data} !== {rd, exp})
                  $display("FAIL wb_payload op=%b: rd/data=%0d/%h required %0d/%h", op, bus.wb_rd, bus.wb_data, rd, exp);
               else n_pass++;
            end
         end
      end
      n_checks++;
      if (pulses != 1 || at != 3)
         $display("FAIL wb_timing: %0d pulse(s), last in cycle %0d, required 1 pulse in cycle 3", pulses, at);
      else n_pass++;
      n_checks++;
      if (bus.in_ready !== 1'b1)
         $display("FAIL ready_return: in_ready=%b required 1", bus.in_ready);
      else n_pass++;
      if (legal && rd != 3'd0) mregs[rd] = exp;
      bus.dbg_addr = rd;
      #1;
      n_checks++;
      if (bus.dbg_data !== mregs[rd])
         $display("FAIL reg_after_wb r%0d: got %h required %h", rd, bus.dbg_data, mregs[rd]);
      else n_pass++;
   endtask

   task automatic test_reset_state();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.in_ready, bus.wb_valid, bus.illegal} !== 3'b100)
         $display("FAIL reset_ctrl: ready/wb_valid/illegal=%b%b%b required 100", bus.in_ready, bus.wb_valid, bus.illegal);
      else n_pass++;
      n_checks++;
      if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.wb_rd, bus.wb_data} !== 18'd0)
         $display("FAIL reset_data: a/b/op/rd/data=%h/%h/%h/%h/%h required all 0", bus.alu_a, bus.alu_b, bus.alu_op, bus.wb_rd, bus.wb_data);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int pulses;
      issue(3'b010, 3'd1, 3'd0, 3'd0, 1'b1, 4'b1010);
      put(3'b010, 3'd2, 3'd1, 3'd0, 1'b1, 4'b0001);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.alu_a !== 4'b1010) $display("FAIL exec_before_reset: alu_a=%h required a", bus.alu_a);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.in_ready, bus.wb_valid} !== 2'b10)
         $display("FAIL reset_mid_exec: ready/wb_valid=%b%b required 10", bus.in_ready, bus.wb_valid);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         bus.dbg_addr = 3'(i);
         #1;
         n_checks++;
         if (bus.dbg_data !== 4'd0) $display("FAIL reset_regs r%0d: got %h required 0", i, bus.dbg_data);
         else n_pass++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mregs[i] = 4'd0;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.wb_valid || bus.illegal) pulses++;
      end
      n_checks++;
      if (pulses != 0) $display("FAIL discarded_inflight: %0d writeback pulse(s) required 0", pulses);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         bus.dbg_addr = 3'(i);
         #1;
         n_checks++;
         if (bus.dbg_data !== 4'd0) $display("FAIL regs_after_reset r%0d: got %h required 0", i, bus.dbg_data);
         else n_pass++;
      end
   endtask

   task automatic test_immediates();
      issue(3'b010, 3'd1, 3'd0, 3'd0, 1'b1, 4'b0110);
      issue(3'b010, 3'd2, 3'd0, 3'd0, 1'b1, 4'b0011);
      issue(3'b010, 3'd3, 3'd1, 3'd2, 1'b0, 4'b0000);
      bus.dbg_addr = 3'd3;
      #1;
      n_checks++;
      if (bus.dbg_data !== 4'b1001) $display("FAIL imm_sum r3: got %b required 1001", bus.dbg_data);
      else n_pass++;
   endtask

   task automatic test_wrap_sub();
      issue(3'b010, 3'd4, 3'd0, 3'd0, 1'b1, 4'b1111);
      issue(3'b010, 3'd5, 3'd4, 3'd0, 1'b1, 4'b0001);
      issue(3'b010, 3'd1, 3'd0, 3'd0, 1'b1, 4'b0001);
      issue(3'b110, 3'd6, 3'd0, 3'd1, 1'b0, 4'b0000);
      bus.dbg_addr = 3'd6;
      #1;
      n_checks++;
      if (bus.dbg_data !== 4'b1111) $display("FAIL sub_wrap r6: got %b required 1111", bus.dbg_data);
      else n_pass++;
   endtask

   task automatic test_logic_slt();
      issue(3'b010, 3'd1, 3'd0, 3'd0, 1'b1, 4'b0011);
      issue(3'b010, 3'd2, 3'd0, 3'd0, 1'b1, 4'b0111);
      issue(3'b000, 3'd3, 3'd1, 3'd2, 1'b0, 4'b0000);
      issue(3'b001, 3'd3, 3'd1, 3'd2, 1'b0, 4'b0000);
      bus.dbg_addr = 3'd3;
      #1;
      n_checks++;
      if (bus.dbg_data !== 4'b0111) $display("FAIL or_result r3: got %b required 0111", bus.dbg_data);
      else n_pass++;
      issue(3'b111, 3'd4, 3'd1, 3'd2, 1'b0, 4'b0000);
      issue(3'b111, 3'd4, 3'd2, 3'd1, 1'b0, 4'b0000);
      // signed compare: -8 < 7
      issue(3'b010, 3'd5, 3'd0, 3'd0, 1'b1, 4'b1000);
      issue(3'b111, 3'd6, 3'd5, 3'd2, 1'b0, 4'b0000);
   endtask

   task automatic test_illegal_r0();
      issue(3'b100, 3'd3, 3'd1, 3'd2, 1'b0, 4'b0000);
      for (int i = 0; i < 8; i++) begin
         bus.dbg_addr = 3'(i);
         #1;
         n_checks++;
         if (bus.dbg_data !== mregs[i]) $display("FAIL illegal_no_write r%0d: got %h required %h", i, bus.dbg_data, mregs[i]);
         else n_pass++;
      end
      issue(3'b010, 3'd0, 3'd0, 3'd0, 1'b1, 4'b0101);
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      int         hs [3];
      logic [6:0] expq [$];
      logic [6:0] gotq [$];
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               logic [2:0] rd, rs;
               logic [3:0] imm, res;
               rd  = 3'($urandom_range(1, 7));
               rs  = 3'($urandom_range(0, 7));
               imm = 4'($urandom);
               put(3'b010, rd, rs, 3'd0, 1'b1, imm);
               bus.in_valid = 1'b1;
               for (int t = 0; t < 16 && !bus.in_ready; t++) @(negedge clk);
               @(posedge clk);
               #1 hs[k] = cyc;
               res = ref_alu(3'b010, mregs[rs], imm);
               expq.push_back({rd, res});
               mregs[rd] = res;
            end
            bus.in_valid = 1'b0;
         end
         begin
            repeat (18) begin
               @(negedge clk);
               if (bus.wb_valid) gotq.push_back({bus.wb_rd, bus.wb_data});
            end
         end
      join
      n_checks++;
      if (hs[1] - hs[0] != 4 || hs[2] - hs[1] != 4)
         $display("FAIL b2b_spacing: gaps %0d,%0d required 4,4", hs[1] - hs[0], hs[2] - hs[1]);
      else n_pass++;
      n_checks++;
      if (gotq.size() != 3) $display("FAIL b2b_count: %0d writebacks required 3", gotq.size());
      else n_pass++;
      for (int i = 0; i < 3 && i < gotq.size(); i++) begin
         n_checks++;
         if (gotq[i] !== expq[i])
            $display("FAIL b2b_wb%0d: rd/data=%0d/%h required %0d/%h", i, gotq[i][6:4], gotq[i][3:0], expq[i][6:4], expq[i][3:0]);
         else n_pass++;
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.dbg_addr = 3'd0;
      put(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 4'd0);
      for (int i = 0; i < 8; i++) mregs[i] = 4'd0;
      test_reset_state();
      test_reset();
      test_immediates();
      test_wrap_sub();
      test_logic_slt();
      test_illegal_r0();
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_4b.md
# alu_issue_4b

Sequential issue and writeback stage wrapped around the combinational `alu_4b`. It holds an 8-entry × 4-bit register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it reads the operands, drives `alu_4b`'s `a`, `b` and `op` inputs, captures `r`, and writes the result back to the destination register. `alu_4b` is instantiated alongside this block, not inside it.

## Interface
- `NREG`, default 8: register count; must be 8 (3-bit register indices).
- `W`, default 4: data width; must be 4 to match `alu_4b`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: block can accept an instruction.
- `in_op` in 3: ALU opcode.
- `in_rd` in 3: destination register index.
- `in_rs` in 3: operand A register index.
- `in_rt` in 3: operand B register index; ignored when `in_use_imm` = 1.
- `in_use_imm` in 1: operand B comes from `in_imm` instead of a register.
- `in_imm` in 4: immediate operand B.
- `alu_a` out 4: to `alu_4b.a`.
- `alu_b` out 4: to `alu_4b.b`.
- `alu_op` out 3: to `alu_4b.op`.
- `alu_r` in 4: from `alu_4b.r`.
- `wb_valid` out 1: one-cycle pulse when a writeback occurs.
- `wb_rd` out 3: destination index of that writeback.
- `wb_data` out 4: data of that writeback.
- `illegal` out 1: one-cycle pulse when an instruction with an unsupported opcode is retired.
- `dbg_addr` in 3: debug read index.
- `dbg_data` out 4: combinational read of register `dbg_addr`.

## Operation
- Legal opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- Illegal opcodes: 011, 100, 101.
  - The instruction is accepted and runs through every FSM state.
  - No register write occurs and `wb_valid` stays 0.
  - `illegal` pulses during WB.
- Register 0 always reads 0. Writes to register 0 are dropped, but `wb_valid` still pulses with `wb_rd` = 0.
- The ALU result is written back unmodified:
  - ADD and SUB wrap mod 16.
  - SLT produces 0001 or 0000 as `alu_4b` defines it.
  - This block does no signedness interpretation.
- FSM states:
  - IDLE: `in_ready` = 1. On `in_valid` & `in_ready`, latch op, rd, rs, rt, use_imm and imm; go to READ.
  - READ: latch A = reg[rs]; latch B = use_imm ? imm : reg[rt]; go to EXEC.
  - EXEC: `alu_a`/`alu_b`/`alu_op` are driven from the latched operands; capture `alu_r` into the result register; go to WB.
  - WB: `wb_valid` (or `illegal`) = 1; write reg[rd] at the edge leaving WB; go to IDLE.
- `in_ready` is 0 in READ, EXEC and WB. Instructions are fully serialised, so there are no hazards: a READ always observes the previous instruction's write.
- `alu_a`, `alu_b` and `alu_op` are registered and hold their values until the next READ.
- Reset, asserted at any time:
  - state → IDLE; all registers → 0.
  - `alu_a`, `alu_b`, `alu_op`, `wb_rd` and `wb_data` → 0.
  - `wb_valid` and `illegal` → 0.
  - An in-flight instruction is discarded with no writeback.

## Timing
- Handshake sampled at edge 0; READ during cycle 1; EXEC during cycle 2 (the ALU sees operands here); WB during cycle 3; register updated at edge 4.
- `in_ready` returns to 1 in cycle 4. Throughput is one instruction per 4 cycles.
- `wb_valid`, `wb_rd` and `wb_data` are valid during the WB cycle only.
- `dbg_data` reflects the register array combinationally and shows the new value from edge 4 onward.
- `in_valid` while `in_ready` = 0 is ignored. The producer must hold the instruction stable until it is accepted.

## Structure
- Package `alu_4b_pkg` holds:
  - opcode constants OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT;
  - the state enum IDLE/READ/EXEC/WB;
  - NREG and W;
  - an `is_legal_op` function.
- One sub-module, `regfile_8x4`: two combinational read ports plus a debug read port, one synchronous write port, r0 hard-wired to zero, asynchronous reset to 0.
- The FSM, operand latches and result register live in `alu_issue_4b`.
- The bench instantiates the real `alu_4b` for integration and a behavioural model for unit tests.

## Test plan
- Reset: assert `rst` mid-EXEC → `in_ready` = 1, `wb_valid` = 0 and all registers 0 in the same cycle; afterwards `dbg_data` = 0 for all indices.
- Immediate loads: ADD r1 = r0 + imm 0110, then ADD r2 = r0 + imm 0011, then ADD r3 = r1 + r2.
  - Required writebacks: r1 = 0110, r2 = 0011, r3 = 1001.
  - Each `wb_valid` is exactly 3 cycles after its handshake edge.
- Wrap and SUB:
  - ADD r4 = r0 + imm 1111, then ADD r5 = r4 + imm 0001 → r5 = 0000.
  - SUB r6 = r0 − r1 with r1 = 0001 → r6 = 1111.
- Logic and SLT: r1 = 0011, r2 = 0111.
  - AND r3 = r1 & r2 → 0011.
  - OR → 0111.
  - SLT r1, r2 → 0001; SLT r2, r1 → 0000.
- Illegal op and r0: op 100 → `illegal` pulse, `wb_valid` 0, no register changes. ADD r0 = r0 + imm 0101 → `wb_valid` = 1, `wb_rd` = 0, and r0 still reads 0.
- Back-to-back: `in_valid` held high for 3 instructions → handshakes exactly 4 cycles apart, and no instruction is lost or duplicated.
